l2_mem_write_buffer: RTL and testbench
======================================

# l2_mem_write_buffer

Posted write buffer between the L2 cache and main memory. It absorbs L2 dirty-line evictions, one 64-bit doubleword per entry, into a DEPTH-entry FIFO and drains them to main memory over the address-strobe/we/stb handshake. L2 read misses are serviced by forwarding from the buffer on an address match, or by a memory read otherwise. Writes to an address already queued are coalesced in place.

## Interface
- DEPTH, 4: buffer entries; power of two, minimum 2.
- AW, 32: address width.
- DW, 64: data width, matching the L2–memory data path.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- l2_wr_req  in  1  L2 write request; held with addr/data until acked.
- l2_wr_addr  in  AW  write address.
- l2_wr_data  in  DW  write data.
- l2_wr_ack  out  1  combinational: l2_wr_req && (!l2_full || coalesce_hit); the write is taken at this edge.
- l2_full  out  1  registered; count == DEPTH.
- l2_rd_req  in  1  level read request; addr held stable until l2_rd_valid.
- l2_rd_addr  in  AW  read address.
- l2_rd_data  out  DW  read data; valid while l2_rd_valid is high.
- l2_rd_valid  out  1  one-cycle pulse.
- mem_addrstb  out  1  memory transaction strobe; registered.
- mem_we  out  1  1 = write, 0 = read; stable while mem_addrstb is high.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; sampled on the edge where mem_stb = 1.
- mem_stb  in  1  memory completion strobe; one cycle.
- wbuf_count  out  $clog2(DEPTH+1)  occupied entries.
- fwd_count  out  16  reads served by forwarding; wraps modulo 2^16.

## Operation
- FIFO has head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH. Each entry holds {valid, addr, data}.
- Coalesce: an accepted write whose address matches a valid entry overwrites that entry's data; the count is unchanged.
  - Exception: the head entry while in WR_MEM never coalesces. That write is appended instead.
- Non-coalescing accepted write: appended at tail, count + 1.
- Push and pop on the same edge leave the count unchanged.
- l2_full is evaluated on pre-edge state. When full, a non-coalescing write waits even if a pop happens on that edge.
- FSM states: IDLE, RD_FWD, RD_MEM, RD_RESP, WR_MEM.
- IDLE decision, in priority order:
  1. count == DEPTH → WR_MEM on the head entry.
  2. l2_rd_req && !l2_wr_req:
     - Address match → RD_FWD. l2_rd_data is loaded from the youngest matching entry.
     - No match → RD_MEM.
  3. count > 0 → WR_MEM.
  4. Otherwise stay in IDLE.
- A read concurrent with l2_wr_req is deferred. This guarantees a same-cycle write is visible to the forwarding check.
- RD_FWD: l2_rd_valid = 1 and fwd_count + 1. Next state IDLE.
- RD_MEM: mem_addrstb = 1, mem_we = 0, mem_addr = l2_rd_addr.
  - On the edge where mem_stb = 1, capture mem_rdata into l2_rd_data and go to RD_RESP.
- RD_RESP: l2_rd_valid = 1. Next state IDLE.
- WR_MEM: mem_addrstb = 1, mem_we = 1, mem_addr/mem_wdata = head entry.
  - On the edge where mem_stb = 1, pop the head and go to IDLE.
- The L2 deasserts l2_rd_req at the edge ending the cycle in which l2_rd_valid is high. RD_FWD and RD_RESP ignore l2_rd_req.
- Only one memory transaction is outstanding at a time. mem_stb seen outside RD_MEM/WR_MEM is ignored.

## Timing
- Reset values: all outputs 0 (l2_rd_data, mem_addr, mem_wdata included), count 0, pointers 0, all valid bits cleared, state IDLE.
- Reset asserted mid-transaction: mem_addrstb drops immediately (asynchronously) and buffered entries are discarded.
- Forwarded read: l2_rd_req sampled in IDLE at edge N → l2_rd_valid high in cycle N+1.
- Memory read: l2_rd_valid is high in the cycle after the edge that samples mem_stb.
- mem_addrstb is low for at least one cycle between consecutive memory transactions; the IDLE pass provides this.
- A write is acked in the same cycle it is presented unless blocked by l2_full.
- wbuf_count reflects the post-edge count.

## Test plan
- Reset, then 3 writes (0x100/0xA, 0x108/0xB, 0x110/0xC) with mem_stb returned 2 cycles after each strobe → memory sees three writes in order; wbuf_count 3→0; exactly one idle cycle of mem_addrstb between transactions.
- Fill 4 entries with memory stalled (mem_stb = 0); present a 5th write to a new address → l2_wr_ack = 0 and l2_full = 1. A 5th write to 0x108 is acked and coalesced; the count stays at 4.
- Queue 0x200/0x55 with memory stalled; read 0x200 → l2_rd_valid one cycle after sampling, data 0x55, fwd_count = 1, no memory read issued.
- Read 0x300 with an empty buffer; memory returns 0xDEAD after 3 cycles → mem_we = 0, l2_rd_valid the cycle after mem_stb, data 0xDEAD.
- While head 0x400 is in WR_MEM, write 0x400/0x2 → appended, count 2. A subsequent read of 0x400 forwards 0x2 (youngest match).
- Pulse reset_n low during RD_MEM → mem_addrstb drops asynchronously; count 0, fwd_count 0, state IDLE, no l2_rd_valid.

Source files
------------

// File: rtl/l2_mem_write_buffer.sv
// Posted write buffer between L2 and main memory: a FIFO of evicted doublewords drained
// over the addrstb/we/stb handshake, with in-place coalescing and read forwarding.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | arbitrate: full drain, then L2 read, then background drain
// RD_FWD  | read hit in buffer, l2_rd_data already loaded, pulse valid
// RD_MEM  | read miss, memory read in flight
// RD_RESP | memory read data captured, pulse valid
// WR_MEM  | head entry being written to memory, pop on mem_stb
module l2_mem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       l2_wr_req,
  input  logic [AW-1:0]              l2_wr_addr,
  input  logic [DW-1:0]              l2_wr_data,
  output logic                       l2_wr_ack,
  output logic                       l2_full,
  input  logic                       l2_rd_req,
  input  logic [AW-1:0]              l2_rd_addr,
  output logic [DW-1:0]              l2_rd_data,
  output logic                       l2_rd_valid,
  output logic                       mem_addrstb,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic [DW-1:0]              mem_rdata,
  input  logic                       mem_stb,
  output logic [$clog2(DEPTH+1)-1:0] wbuf_count,
  output logic [15:0]                fwd_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {IDLE, RD_FWD, RD_MEM, RD_RESP, WR_MEM} stateT;

  stateT            state, nextState;
  logic [DEPTH-1:0] entryValid;
  logic [AW-1:0]    entryAddr [DEPTH];
  logic [DW-1:0]    entryData [DEPTH];
  logic [PW-1:0]    headPtr, tailPtr;
  logic [CW-1:0]    count, countNext;
  logic             coalHit, fwdHit, push, pop, headCoal;
  logic [PW-1:0]    coalIdx, fwdIdx;

  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    coalHit = 1'b0;
    coalIdx = '0;
    fwdHit  = 1'b0;
    fwdIdx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[headPtr + PW'(i)] && entryAddr[headPtr + PW'(i)] == l2_wr_addr &&
          !(state == WR_MEM && i == 0)) begin
        coalHit = 1'b1;
        coalIdx = headPtr + PW'(i);
      end
      if (entryValid[headPtr + PW'(i)] && entryAddr[headPtr + PW'(i)] == l2_rd_addr) begin
        fwdHit = 1'b1;
        fwdIdx = headPtr + PW'(i);
      end
    end
  end

  assign l2_wr_ack   = l2_wr_req && (!l2_full || coalHit);
  assign push        = l2_wr_ack && !coalHit;
  assign pop         = (state == WR_MEM) && mem_stb;
  assign countNext   = count + CW'(push) - CW'(pop);
  assign headCoal    = l2_wr_ack && coalHit && (coalIdx == headPtr);
  assign l2_rd_valid = (state == RD_FWD) || (state == RD_RESP);
  assign wbuf_count  = count;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (count == CW'(DEPTH))            nextState = WR_MEM;
        else if (l2_rd_req && !l2_wr_req)   nextState = fwdHit ? RD_FWD : RD_MEM;
        else if (count != '0)               nextState = WR_MEM;
      end
      RD_FWD:  nextState = IDLE;
      RD_MEM:  if (mem_stb) nextState = RD_RESP;
      RD_RESP: nextState = IDLE;
      WR_MEM:  if (mem_stb) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entryValid <= '0;
      headPtr    <= '0;
      tailPtr    <= '0;
      count      <= '0;
      l2_full    <= 1'b0;
    end else begin
      if (pop) begin
        entryValid[headPtr] <= 1'b0;
        headPtr             <= headPtr + PW'(1);
      end
      if (push) begin
        entryValid[tailPtr] <= 1'b1;
        tailPtr             <= tailPtr + PW'(1);
      end
      count   <= countNext;
      l2_full <= (countNext == CW'(DEPTH));
    end
  end

  // Payload needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      entryAddr[tailPtr] <= l2_wr_addr;
      entryData[tailPtr] <= l2_wr_data;
    end else if (l2_wr_ack) begin
      entryData[coalIdx] <= l2_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      mem_addrstb <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      l2_rd_data  <= '0;
      fwd_count   <= '0;
    end else begin
      state       <= nextState;
      mem_addrstb <= (nextState == RD_MEM) || (nextState == WR_MEM);
      mem_we      <= (nextState == WR_MEM);
      // A write coalescing into the head on the launch edge must reach memory, not the stale copy.
      if (nextState == WR_MEM) begin
        mem_addr  <= entryAddr[headPtr];
        mem_wdata <= headCoal ? l2_wr_data : entryData[headPtr];
      end else if (nextState == RD_MEM) begin
        mem_addr  <= l2_rd_addr;
      end
      if (state == IDLE && nextState == RD_FWD)
        l2_rd_data <= entryData[fwdIdx];
      else if (state == RD_MEM && mem_stb)
        l2_rd_data <= mem_rdata;
      if (state == RD_FWD)
        fwd_count <= fwd_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_l2_mem_write_buffer.sv
// Bench for l2_mem_write_buffer: write vector table plus hand sequences, with a memory
// responder that checks each memory transaction against a queue of expected ones.
module tb_l2_mem_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          l2_wr_req;
  logic [AW-1:0] l2_wr_addr;
  logic [DW-1:0] l2_wr_data;
  logic          l2_wr_ack;
  logic          l2_full;
  logic          l2_rd_req;
  logic [AW-1:0] l2_rd_addr;
  logic [DW-1:0] l2_rd_data;
  logic          l2_rd_valid;
  logic          mem_addrstb;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_stb;
  logic [CW-1:0] wbuf_count;
  logic [15:0]   fwd_count;

  l2_mem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .l2_wr_req(l2_wr_req), .l2_wr_addr(l2_wr_addr), .l2_wr_data(l2_wr_data),
    .l2_wr_ack(l2_wr_ack), .l2_full(l2_full),
    .l2_rd_req(l2_rd_req), .l2_rd_addr(l2_rd_addr), .l2_rd_data(l2_rd_data),
    .l2_rd_valid(l2_rd_valid),
    .mem_addrstb(mem_addrstb), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stb(mem_stb),
    .wbuf_count(wbuf_count), .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          expAck;
    logic          expFull;
    logic [CW-1:0] expCount;
    logic          push;
  } wrVecT;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } memTxnT;

  memTxnT  expQ[$];
  wrVecT   vecs [9];
  int      vecCnt = 0;
  int      missCnt = 0;
  int      cycCnt = 0;
  int      stbCyc = 0;
  int      rdStrobes = 0;
  int      gapCnt = 0;
  bit      gapValid = 0;
  bit      checkGap = 0;
  bit      memEn = 0;
  int      memLat = 2;
  logic [DW-1:0] memRdVal = '0;

  always @(posedge clk) cycCnt <= cycCnt + 1;
  always @(negedge clk) if (mem_addrstb && !mem_we) rdStrobes <= rdStrobes + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCnt++;
    if (act !== exp) begin
      missCnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: acknowledges each strobe after memLat cycles while enabled.
  initial begin
    int     respWait;
    bit     pending;
    memTxnT e;
    mem_stb   = 1'b0;
    mem_rdata = '0;
    pending   = 0;
    respWait  = 0;
    forever begin
      @(negedge clk);
      mem_stb = 1'b0;
      if (!memEn || !reset_n) pending = 0;
      if (!mem_addrstb) gapCnt++;
      if (memEn && reset_n && mem_addrstb && !pending) begin
        if (checkGap && gapValid) check("mem_idle_gap", 64'(gapCnt), 64'(1));
        if (expQ.size() == 0) begin
          vecCnt++;
          missCnt++;
          $display("FAIL mem_unexpected: got txn we=%0b addr %0h expected none", mem_we, mem_addr);
        end else begin
          e = expQ.pop_front();
          check("mem_we", 64'(mem_we), 64'(e.we));
          check("mem_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) check("mem_wdata", mem_wdata, e.data);
        end
        pending  = 1;
        respWait = memLat;
      end
      if (pending) begin
        if (respWait <= 1) begin
          mem_stb   = 1'b1;
          mem_rdata = memRdVal;
          stbCyc    = cycCnt;
          pending   = 0;
          gapCnt    = 0;
          gapValid  = checkGap;
        end else begin
          respWait--;
        end
      end
    end
  end

  task automatic applyRange(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      l2_wr_req  = 1'b1;
      l2_wr_addr = vecs[i].addr;
      l2_wr_data = vecs[i].data;
      if (vecs[i].push) expQ.push_back('{1'b1, vecs[i].addr, vecs[i].data});
      #1;
      check($sformatf("wr%0d_ack", i), 64'(l2_wr_ack), 64'(vecs[i].expAck));
      check($sformatf("wr%0d_full", i), 64'(l2_full), 64'(vecs[i].expFull));
      @(negedge clk);
      check($sformatf("wr%0d_count", i), 64'(wbuf_count), 64'(vecs[i].expCount));
    end
    l2_wr_req = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || wbuf_count != 0 || mem_addrstb) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_in_time"}, 64'(n < 200), 64'(1));
  endtask

  task automatic waitRdValid(input string name);
    int n = 0;
    while (!l2_rd_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_rd_valid_in_time"}, 64'(l2_rd_valid), 64'(1));
  endtask

  initial begin
    int rdBefore;
    int bad;
    vecs[0] = '{32'h100, 64'hA,  1'b1, 1'b0, 3'd1, 1'b1};
    vecs[1] = '{32'h108, 64'hB,  1'b1, 1'b0, 3'd2, 1'b1};
    vecs[2] = '{32'h110, 64'hC,  1'b1, 1'b0, 3'd3, 1'b1};
    vecs[3] = '{32'h100, 64'h11, 1'b1, 1'b0, 3'd1, 1'b0};
    vecs[4] = '{32'h108, 64'h12, 1'b1, 1'b0, 3'd2, 1'b0};
    vecs[5] = '{32'h110, 64'h13, 1'b1, 1'b0, 3'd3, 1'b0};
    vecs[6] = '{32'h118, 64'h14, 1'b1, 1'b0, 3'd4, 1'b0};
    vecs[7] = '{32'h120, 64'h15, 1'b0, 1'b1, 3'd4, 1'b0};
    vecs[8] = '{32'h108, 64'h22, 1'b1, 1'b1, 3'd4, 1'b0};

    reset_n    = 1'b0;
    l2_wr_req  = 1'b0;
    l2_wr_addr = '0;
    l2_wr_data = '0;
    l2_rd_req  = 1'b0;
    l2_rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_wr_ack", 64'(l2_wr_ack), 64'(0));
    check("rst_full", 64'(l2_full), 64'(0));
    check("rst_rd_data", l2_rd_data, 64'(0));
    check("rst_rd_valid", 64'(l2_rd_valid), 64'(0));
    check("rst_addrstb", 64'(mem_addrstb), 64'(0));
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", mem_wdata, 64'(0));
    check("rst_count", 64'(wbuf_count), 64'(0));
    check("rst_fwd_count", 64'(fwd_count), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_no_strobe", 64'(mem_addrstb), 64'(0));

    // Three writes drained in order with one idle strobe cycle between them.
    memEn    = 1;
    memLat   = 2;
    checkGap = 1;
    gapValid = 0;
    applyRange(0, 2);
    drain("drain3");
    check("drain3_count", 64'(wbuf_count), 64'(0));
    checkGap = 0;

    // Fill with memory stalled, then blocked new write and coalescing write.
    memEn = 0;
    applyRange(3, 8);
    check("full_after_fill", 64'(l2_full), 64'(1));
    expQ.push_back('{1'b1, 32'h100, 64'h11});
    expQ.push_back('{1'b1, 32'h108, 64'h22});
    expQ.push_back('{1'b1, 32'h110, 64'h13});
    expQ.push_back('{1'b1, 32'h118, 64'h14});
    memEn = 1;
    drain("drain_full");

    // Forwarded read from a queued entry, no memory read.
    memEn      = 0;
    rdBefore   = rdStrobes;
    l2_wr_req  = 1'b1;
    l2_wr_addr = 32'h200;
    l2_wr_data = 64'h55;
    #1 check("fwd_wr_ack", 64'(l2_wr_ack), 64'(1));
    @(negedge clk);
    l2_wr_req  = 1'b0;
    l2_rd_req  = 1'b1;
    l2_rd_addr = 32'h200;
    @(negedge clk);
    check("fwd_rd_valid", 64'(l2_rd_valid), 64'(1));
    check("fwd_rd_data", l2_rd_data, 64'h55);
    l2_rd_req = 1'b0;
    @(negedge clk);
    check("fwd_valid_pulse", 64'(l2_rd_valid), 64'(0));
    check("fwd_count1", 64'(fwd_count), 64'(1));
    @(negedge clk);
    check("fwd_no_mem_read", 64'(rdStrobes), 64'(rdBefore));
    expQ.push_back('{1'b1, 32'h200, 64'h55});
    memEn  = 1;
    memLat = 2;
    drain("drain_fwd");

    // Write to the head while it is being written is appended; read forwards the new copy.
    memEn      = 0;
    l2_wr_req  = 1'b1;
    l2_wr_addr = 32'h400;
    l2_wr_data = 64'h1;
    #1 check("hd_wr1_ack", 64'(l2_wr_ack), 64'(1));
    @(negedge clk);
    l2_wr_req = 1'b0;
    @(negedge clk);
    check("hd_strobe", 64'(mem_addrstb), 64'(1));
    check("hd_we", 64'(mem_we), 64'(1));
    check("hd_addr", 64'(mem_addr), 64'h400);
    check("hd_wdata", mem_wdata, 64'h1);
    l2_wr_req  = 1'b1;
    l2_wr_data = 64'h2;
    #1 check("hd_wr2_ack", 64'(l2_wr_ack), 64'(1));
    @(negedge clk);
    check("hd_count2", 64'(wbuf_count), 64'(2));
    l2_wr_req  = 1'b0;
    l2_rd_req  = 1'b1;
    l2_rd_addr = 32'h400;
    expQ.push_back('{1'b1, 32'h400, 64'h1});
    expQ.push_back('{1'b1, 32'h400, 64'h2});
    memEn  = 1;
    memLat = 1;
    waitRdValid("hd");
    check("hd_fwd_data", l2_rd_data, 64'h2);
    l2_rd_req = 1'b0;
    drain("drain_hd");
    check("hd_fwd_count2", 64'(fwd_count), 64'(2));

    // Read miss serviced by memory.
    memLat   = 3;
    memRdVal = 64'hDEAD;
    expQ.push_back('{1'b0, 32'h300, 64'h0});
    l2_rd_req  = 1'b1;
    l2_rd_addr = 32'h300;
    waitRdValid("mrd");
    check("mrd_data", l2_rd_data, 64'hDEAD);
    check("mrd_latency", 64'(cycCnt), 64'(stbCyc + 1));
    check("mrd_issued", 64'(expQ.size()), 64'(0));
    l2_rd_req = 1'b0;
    @(negedge clk);
    check("mrd_valid_pulse", 64'(l2_rd_valid), 64'(0));
    check("mrd_fwd_unchanged", 64'(fwd_count), 64'(2));

    // Reset in the middle of a memory read with an entry buffered.
    memEn      = 0;
    l2_wr_req  = 1'b1;
    l2_wr_addr = 32'h600;
    l2_wr_data = 64'h7;
    @(negedge clk);
    l2_wr_req  = 1'b0;
    l2_rd_req  = 1'b1;
    l2_rd_addr = 32'h500;
    @(negedge clk);
    check("rst_mid_strobe", 64'(mem_addrstb), 64'(1));
    check("rst_mid_we", 64'(mem_we), 64'(0));
    check("rst_mid_addr", 64'(mem_addr), 64'h500);
    check("rst_mid_count", 64'(wbuf_count), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check("arst_strobe", 64'(mem_addrstb), 64'(0));
    check("arst_count", 64'(wbuf_count), 64'(0));
    check("arst_fwd_count", 64'(fwd_count), 64'(0));
    check("arst_rd_valid", 64'(l2_rd_valid), 64'(0));
    l2_rd_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_addrstb || l2_rd_valid || wbuf_count != 0) bad++;
    end
    check("post_reset_quiet", 64'(bad), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
